// File: rtl/iagc_pkg.sv
// IAGC system status codes shared by the waveform generator and the amplitude detector.
package iagc_pkg;

  localparam logic [3:0] IAGC_RESET = 4'b0000;
  localparam logic [3:0] IAGC_INIT  = 4'b0001;

endpackage

// File: rtl/waveform_generator_pkg.sv
// State encoding for the triangular waveform generator FSM.
package waveform_generator_pkg;

  typedef logic [1:0] wg_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_FALL = 2'd2;

endpackage

// File: rtl/waveform_generator_if.sv
// Control/status bundle of the waveform generator; the generator sits on the slave side.
interface waveform_generator_if #(
  parameter int IAGC_STATUS_SIZE  = 4,
  parameter int SAMPLER_DATA_SIZE = 16,
  parameter int DIVIDER_SIZE      = 16
);
  // No valid/ready here: o_sample is a one-clock strobe that qualifies o_reference
  // and o_peak in the same cycle; the consumer must take them then or lose them.
  logic [IAGC_STATUS_SIZE-1:0]  i_iagc_status;
  logic [SAMPLER_DATA_SIZE-1:0] i_amplitude;
  logic [SAMPLER_DATA_SIZE-1:0] i_step;
  logic [DIVIDER_SIZE-1:0]      i_sample_divider;
  logic                         o_sample;
  logic [SAMPLER_DATA_SIZE-1:0] o_reference;
  logic                         o_peak;
  logic                         o_busy;
  logic [1:0]                   o_state;

  modport master (
    output i_iagc_status, i_amplitude, i_step, i_sample_divider,
    input  o_sample, o_reference, o_peak, o_busy, o_state
  );

  modport slave (
    input  i_iagc_status, i_amplitude, i_step, i_sample_divider,
    output o_sample, o_reference, o_peak, o_busy, o_state
  );
endinterface

// File: rtl/waveform_generator_divider.sv
// Sample-rate divider: free-running counter that strobes and wraps when it reaches the divider value.
module sample_strobe_divider #(
  parameter int DIVIDER_SIZE = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic [DIVIDER_SIZE-1:0] divider_i,
  output logic                    strobe_o
);

  logic [DIVIDER_SIZE-1:0] count_q, count_d;

  // >= so that lowering the divider below the running count wraps at the next compare
  // instead of running through the whole counter range.
  assign strobe_o = !clear_i && (count_q >= divider_i);

  always_comb begin
    count_d = count_q + DIVIDER_SIZE'(1);
    if (clear_i || strobe_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/waveform_generator.sv
// Triangular reference generator: ramps up to a latched amplitude and back to zero, one step per sample strobe.
module waveform_generator
  import iagc_pkg::*;
  import waveform_generator_pkg::*;
#(
  parameter int IAGC_STATUS_SIZE  = 4,
  parameter int SAMPLER_DATA_SIZE = 16,
  parameter int DIVIDER_SIZE      = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  waveform_generator_if.slave  bus
);

  localparam int W = SAMPLER_DATA_SIZE;

  wg_state_t    state_q, state_d;
  logic [W-1:0] ref_q, ref_d;
  logic [W-1:0] amp_q, amp_d;
  logic         sample_q, sample_d;
  logic         peak_q, peak_d;

  logic         status_reset;
  logic         sample_evt;
  logic [W-1:0] step_eff;
  logic [W:0]   rise_sum;
  logic [W-1:0] rise_val;
  logic [W-1:0] fall_val;

  assign status_reset = (bus.i_iagc_status == IAGC_STATUS_SIZE'(IAGC_RESET));

  sample_strobe_divider #(
    .DIVIDER_SIZE (DIVIDER_SIZE)
  ) u_divider (
    .clk_i     (i_clock),
    .rst_i     (i_reset),
    .clear_i   ((state_q == ST_IDLE) || status_reset),
    .divider_i (bus.i_sample_divider),
    .strobe_o  (sample_evt)
  );

  // A zero step would stall the ramp forever, so it behaves as a step of one.
  assign step_eff = (bus.i_step == '0) ? W'(1) : bus.i_step;
  assign rise_sum = {1'b0, ref_q} + {1'b0, step_eff};
  assign rise_val = (rise_sum >= {1'b0, amp_q}) ? amp_q : rise_sum[W-1:0];
  assign fall_val = (ref_q > step_eff) ? (ref_q - step_eff) : '0;

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    amp_d    = amp_q;
    sample_d = 1'b0;
    peak_d   = 1'b0;
    if (status_reset) begin
      state_d = ST_IDLE;
      ref_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RISE;
          amp_d   = bus.i_amplitude;
          ref_d   = '0;
        end
        ST_RISE: begin
          if (sample_evt) begin
            sample_d = 1'b1;
            ref_d    = rise_val;
            // A zero amplitude keeps the ramp parked at 0 without ever peaking.
            if ((amp_q != '0) && (rise_val == amp_q)) begin
              peak_d  = 1'b1;
              state_d = ST_FALL;
            end
          end
        end
        ST_FALL: begin
          if (sample_evt) begin
            sample_d = 1'b1;
            ref_d    = fall_val;
            if (fall_val == '0) begin
              state_d = ST_RISE;
              amp_d   = bus.i_amplitude;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          ref_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      ref_q    <= '0;
      amp_q    <= '0;
      sample_q <= 1'b0;
      peak_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      amp_q    <= amp_d;
      sample_q <= sample_d;
      peak_q   <= peak_d;
    end
  end

  assign bus.o_sample    = sample_q;
  assign bus.o_reference = ref_q;
  assign bus.o_peak      = peak_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_state     = state_q;

endmodule

// File: tb/tb_waveform_generator.sv
// Directed bench for waveform_generator: table of ramp vectors plus hand-written corner sequences.
module tb_waveform_generator;
  import iagc_pkg::*;

  logic clk;
  logic rst;

  waveform_generator_if #(
    .IAGC_STATUS_SIZE  (4),
    .SAMPLER_DATA_SIZE (16),
    .DIVIDER_SIZE      (16)
  ) bus ();

  waveform_generator #(
    .IAGC_STATUS_SIZE  (4),
    .SAMPLER_DATA_SIZE (16),
    .DIVIDER_SIZE      (16)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err    = 0;
  int stray_peaks = 0;
  logic [16:0] exp_q[$];   // {peak, reference}

  typedef struct packed {
    logic [15:0]        div;
    logic [15:0]        amp;
    logic [15:0]        step;
    logic [3:0]         n;
    logic [0:7][15:0]   exp_ref;
    logic [0:7]         exp_peak;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    bus.i_iagc_status = IAGC_RESET;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic configure(input logic [15:0] div, input logic [15:0] amp, input logic [15:0] step);
    bus.i_sample_divider = div;
    bus.i_amplitude      = amp;
    bus.i_step           = step;
  endtask

  task automatic push_exp(input logic [15:0] r, input logic pk);
    exp_q.push_back({pk, r});
  endtask

  // Waits for the next o_sample, counting posedges; peaks outside strobes are tallied.
  task automatic wait_strobe(input int budget, output int cycles, output logic ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget && !ok) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.o_sample) ok = 1'b1;
      else if (bus.o_peak) stray_peaks++;
    end
  endtask

  // Waits for one strobe and checks its latency and payload against the queue head.
  task automatic expect_strobe(input string name, input int exp_cycles);
    int cyc;
    logic ok;
    logic [16:0] e;
    wait_strobe(exp_cycles + 20, cyc, ok);
    if (!ok) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({name, "_interval"}, cyc, exp_cycles);
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_ref"},  bus.o_reference, e[15:0]);
    check({name, "_peak"}, bus.o_peak,      e[16]);
  endtask

  // ---------------- test ----------------
  initial begin
    int d;
    rst = 1'b1;
    bus.i_iagc_status    = IAGC_RESET;
    bus.i_amplitude      = '0;
    bus.i_step           = '0;
    bus.i_sample_divider = '0;

    vecs[0] = '{div:16'd3, amp:16'd10, step:16'd4, n:4'd8,
                exp_ref:{16'd4, 16'd8, 16'd10, 16'd6, 16'd2, 16'd0, 16'd4, 16'd8},
                exp_peak:8'b0010_0000};
    vecs[1] = '{div:16'd0, amp:16'hFFFF, step:16'hFFF0, n:4'd8,
                exp_ref:{16'hFFF0, 16'hFFFF, 16'h000F, 16'h0000, 16'hFFF0, 16'hFFFF, 16'h000F, 16'h0000},
                exp_peak:8'b0100_0100};
    vecs[2] = '{div:16'd1, amp:16'd3, step:16'd0, n:4'd8,
                exp_ref:{16'd1, 16'd2, 16'd3, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2},
                exp_peak:8'b0010_0000};
    vecs[3] = '{div:16'd1, amp:16'd0, step:16'd0, n:4'd6,
                exp_ref:{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                exp_peak:8'b0000_0000};
    vecs[4] = '{div:16'd2, amp:16'd7, step:16'd3, n:4'd8,
                exp_ref:{16'd3, 16'd6, 16'd7, 16'd4, 16'd1, 16'd0, 16'd3, 16'd6},
                exp_peak:8'b0010_0000};

    // Reset state
    apply_reset();
    check("rst_ref",    bus.o_reference, 32'd0);
    check("rst_sample", bus.o_sample,    32'd0);
    check("rst_peak",   bus.o_peak,      32'd0);
    check("rst_busy",   bus.o_busy,      32'd0);
    check("rst_state",  bus.o_state,     32'd0);

    // Table-driven ramps
    for (int v = 0; v < 5; v++) begin
      apply_reset();
      exp_q.delete();
      stray_peaks = 0;
      configure(vecs[v].div, vecs[v].amp, vecs[v].step);
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        push_exp(vecs[v].exp_ref[i], vecs[v].exp_peak[i]);
      end
      bus.i_iagc_status = IAGC_INIT;
      d = int'(vecs[v].div);
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        expect_strobe($sformatf("vec%0d_s%0d", v, i), (i == 0) ? d + 2 : d + 1);
      end
      check($sformatf("vec%0d_busy", v), bus.o_busy, 32'd1);
      check($sformatf("vec%0d_stray_peak", v), stray_peaks, 32'd0);
    end

    // Amplitude change mid-RISE only takes effect at the next turn-around
    apply_reset();
    exp_q.delete();
    configure(16'd3, 16'd10, 16'd4);
    push_exp(16'd4, 1'b0);
    bus.i_iagc_status = IAGC_INIT;
    expect_strobe("ampchg_s0", 5);
    bus.i_amplitude = 16'd20;
    push_exp(16'd8, 1'b0);  push_exp(16'd10, 1'b1); push_exp(16'd6, 1'b0);
    push_exp(16'd2, 1'b0);  push_exp(16'd0, 1'b0);  push_exp(16'd4, 1'b0);
    push_exp(16'd8, 1'b0);  push_exp(16'd12, 1'b0); push_exp(16'd16, 1'b0);
    push_exp(16'd20, 1'b1); push_exp(16'd16, 1'b0);
    for (int i = 1; i < 12; i++) expect_strobe($sformatf("ampchg_s%0d", i), 4);

    // Status forced to RESET while falling at 6, then released
    apply_reset();
    exp_q.delete();
    configure(16'd3, 16'd10, 16'd4);
    push_exp(16'd4, 1'b0); push_exp(16'd8, 1'b0); push_exp(16'd10, 1'b1); push_exp(16'd6, 1'b0);
    bus.i_iagc_status = IAGC_INIT;
    for (int i = 0; i < 4; i++) expect_strobe($sformatf("stat_s%0d", i), (i == 0) ? 5 : 4);
    check("stat_in_fall", bus.o_state, 32'd2);
    bus.i_iagc_status = IAGC_RESET;
    @(posedge clk);
    #1;
    check("stat_ref0",   bus.o_reference, 32'd0);
    check("stat_busy0",  bus.o_busy,      32'd0);
    check("stat_nostrb", bus.o_sample,    32'd0);
    bus.i_iagc_status = IAGC_INIT;
    push_exp(16'd4, 1'b0);
    expect_strobe("stat_release", 5);

    // Divider change takes effect at the next compare
    apply_reset();
    exp_q.delete();
    configure(16'd3, 16'd100, 16'd1);
    push_exp(16'd1, 1'b0); push_exp(16'd2, 1'b0); push_exp(16'd3, 1'b0);
    bus.i_iagc_status = IAGC_INIT;
    expect_strobe("divchg_s0", 5);
    bus.i_sample_divider = 16'd1;
    expect_strobe("divchg_s1", 2);
    expect_strobe("divchg_s2", 2);

    // Reset on a sample-event clock wins over the strobe
    apply_reset();
    exp_q.delete();
    configure(16'd3, 16'd10, 16'd4);
    push_exp(16'd4, 1'b0);
    bus.i_iagc_status = IAGC_INIT;
    expect_strobe("rstevt_s0", 5);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstevt_sample", bus.o_sample,    32'd0);
    check("rstevt_ref",    bus.o_reference, 32'd0);
    check("rstevt_peak",   bus.o_peak,      32'd0);
    check("rstevt_busy",   bus.o_busy,      32'd0);
    rst = 1'b0;

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
